trace_drain_ctrl: RTL and testbench



---
 rtl/trace_drain_ctrl_if.sv | 21 ++
 rtl/trace_drain_ctrl.sv | 133 +++++++++++++
 tb/tb_trace_drain_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_drain_ctrl_if.sv
// Record ingress from the trace unit and valid/ready egress toward the reader.
interface trace_drain_ctrl_if #(
  parameter int RECORD_WIDTH = 96
) ();
  logic                    trace_valid_i;
  logic [RECORD_WIDTH-1:0] trace_data_i;
  logic                    trace_capture_enable_i;
  logic                    out_valid_o;
  logic [RECORD_WIDTH-1:0] out_data_o;
  logic                    out_ready_i;

  modport master (
    output trace_valid_i, trace_data_i, trace_capture_enable_i, out_ready_i,
    input  out_valid_o, out_data_o
  );

  modport slave (
    input  trace_valid_i, trace_data_i, trace_capture_enable_i, out_ready_i,
    output out_valid_o, out_data_o
  );
endinterface

// File: rtl/trace_drain_ctrl.sv
// Capture/drain sequencer for trace records: gates capture, buffers records in a
// FIFO and streams them out, then reports done once the buffer has been drained.
module trace_drain_ctrl #(
  parameter int RECORD_WIDTH   = 96,
  parameter int FIFO_DEPTH     = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic                        lock_i,
  trace_drain_ctrl_if.slave           bus,
  output logic                        capture_gate_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        overflow_o,
  output logic [DROP_CNT_WIDTH-1:0]   drop_count_o,
  output logic [1:0]                  state_o,
  output logic                        done_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [AW:0]               wr_ptr_q, wr_ptr_d;
  logic [AW:0]               rd_ptr_q, rd_ptr_d;
  logic [RECORD_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic                      out_valid_q, out_valid_d;
  logic [RECORD_WIDTH-1:0]   out_data_q, out_data_d;
  logic                      gate_q, gate_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic [AW:0] count_s, count_d;
  logic        push_s, pop_s, full_s, accept_s, drop_s, clear_s;

  // Next-state logic of the session sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_i) state_d = ST_CAPTURE; else state_d = ST_IDLE;
      ST_CAPTURE: if (lock_i || stop_i) state_d = ST_DRAIN; else state_d = ST_CAPTURE;
      ST_DRAIN:   if (count_s == '0) state_d = ST_DONE; else state_d = ST_DRAIN;
      ST_DONE:    if (start_i) state_d = ST_CAPTURE; else state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping, drop accounting and next values of the registered outputs.
  always_comb begin
    count_s    = wr_ptr_q - rd_ptr_q;
    full_s     = (count_s == DEPTH_C);
    push_s     = (state_q == ST_CAPTURE) && bus.trace_valid_i && bus.trace_capture_enable_i;
    pop_s      = out_valid_q && bus.out_ready_i;
    accept_s   = push_s && (!full_s || pop_s);
    drop_s     = push_s && full_s && !pop_s;
    clear_s    = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, accept_s};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop_s};
    count_d    = wr_ptr_d - rd_ptr_d;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    out_data_d = out_data_q;
    if (clear_s) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop_s) begin
      ovf_d = 1'b1;
      if (drop_q != {DROP_CNT_WIDTH{1'b1}}) drop_d = drop_q + DROP_CNT_WIDTH'(1);
      else drop_d = drop_q;
    end else begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
    end
    out_valid_d = ((state_d == ST_CAPTURE) || (state_d == ST_DRAIN)) && (count_d != '0);
    // A record written into an otherwise-empty FIFO becomes the head on the same edge.
    if (out_valid_d) begin
      if (rd_ptr_d == wr_ptr_q) out_data_d = bus.trace_data_i;
      else out_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end else begin
      out_data_d = out_data_q;
    end
    gate_d = (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      gate_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      gate_q      <= gate_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  // Record storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (accept_s) mem_q[wr_ptr_q[AW-1:0]] <= bus.trace_data_i;
  end

  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_data_o   = out_data_q;
  assign capture_gate_o   = gate_q;
  assign fifo_count_o     = wr_ptr_q - rd_ptr_q;
  assign overflow_o       = ovf_q;
  assign drop_count_o     = drop_q;
  assign state_o          = state_q;
  assign done_o           = done_q;
endmodule

// File: tb/tb_trace_drain_ctrl.sv
// Self-checking bench: vector table, directed corner sequences and random stimulus
// against a queue-based reference model of the capture/drain behaviour.
module tb_trace_drain_ctrl;
  localparam int RW = 96;
  localparam int D  = 8;
  localparam int DW = 16;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start_i, stop_i, lock_i;
  logic          gate, ovf, done;
  logic [CW-1:0] cnt;
  logic [DW-1:0] drop;
  logic [1:0]    st;

  trace_drain_ctrl_if #(.RECORD_WIDTH(RW)) bus ();

  trace_drain_ctrl #(.RECORD_WIDTH(RW), .FIFO_DEPTH(D), .DROP_CNT_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .lock_i(lock_i),
    .bus(bus), .capture_gate_o(gate), .fifo_count_o(cnt), .overflow_o(ovf),
    .drop_count_o(drop), .state_o(st), .done_o(done)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: session phase, record queue, sticky overflow and drop tally.
  logic [RW-1:0] mq[$];
  int            mst = 0;
  bit            movf = 1'b0;
  int            mdrop = 0;
  logic [RW-1:0] mdata = '0;

  typedef struct {
    bit r, s, sp, tv, en, lk, rdy;
    logic [RW-1:0] d;
    logic [1:0] e_st; int e_cnt; bit e_vld; logic [RW-1:0] e_data;
    bit e_gate, e_ovf; int e_drop; bit e_done;
  } vec_t;

  localparam logic [RW-1:0] RA = 96'hA0A0_0000_1111_2222_3333_000A;
  localparam logic [RW-1:0] RB = 96'hB0B0_4444_5555_6666_7777_000B;
  localparam logic [RW-1:0] RC = 96'hC0C0_8888_9999_AAAA_BBBB_000C;
  localparam logic [RW-1:0] RD = 96'hD0D0_CCCC_DDDD_EEEE_FFFF_000D;
  localparam logic [RW-1:0] RE = 96'hE0E0_1234_5678_9ABC_DEF0_000E;

  function automatic logic [RW-1:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] pack_out(logic [1:0] s_, int c_, bit v_, logic [RW-1:0] d_,
                                            bit g_, bit o_, int dr_, bit dn_);
    return {s_, CW'(c_), v_, d_, g_, o_, DW'(dr_), dn_};
  endfunction

  function automatic logic [127:0] act_out();
    return pack_out(st, int'(cnt), bus.out_valid_o, bus.out_data_o, gate, ovf, int'(drop), done);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input bit r, s, sp, tv, en, lk, rdy, input logic [RW-1:0] d);
    bit vld;
    int sz0;
    int nst;
    if (r) begin
      mq.delete(); mst = 0; movf = 1'b0; mdrop = 0; mdata = '0;
      return;
    end
    vld = ((mst == 1) || (mst == 2)) && (mq.size() > 0);
    sz0 = mq.size();
    nst = mst;
    case (mst)
      0: if (s) nst = 1;
      1: if (lk || sp) nst = 2;
      2: if (sz0 == 0) nst = 3;
      3: if (s) nst = 1;
      default: nst = 0;
    endcase
    if (vld && rdy) void'(mq.pop_front());
    if ((mst == 1) && tv && en) begin
      if ((sz0 < D) || (vld && rdy)) mq.push_back(d);
      else begin
        movf = 1'b1;
        if (mdrop < 65535) mdrop++;
      end
    end
    if (s && ((mst == 0) || (mst == 3))) begin movf = 1'b0; mdrop = 0; end
    mst = nst;
    if (((mst == 1) || (mst == 2)) && (mq.size() > 0)) mdata = mq[0];
  endtask

  function automatic logic [127:0] model_out();
    bit v;
    v = ((mst == 1) || (mst == 2)) && (mq.size() > 0);
    return pack_out(2'(mst), mq.size(), v, mdata, mst == 1, movf, mdrop, mst == 3);
  endfunction

  // One clock: drive inputs, advance the model, sample after the edge and compare.
  task automatic drive(input bit r, s, sp, tv, en, lk, rdy, input logic [RW-1:0] d);
    rst = r; start_i = s; stop_i = sp; lock_i = lk;
    bus.trace_valid_i = tv; bus.trace_capture_enable_i = en;
    bus.trace_data_i = d; bus.out_ready_i = rdy;
    model_step(r, s, sp, tv, en, lk, rdy, d);
    @(posedge clk);
    #1;
    check("model", act_out(), model_out());
  endtask

  task automatic idle_cyc(input bit rdy);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy, '0);
  endtask

  task automatic push(input logic [RW-1:0] d, input bit rdy);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, rdy, d);
  endtask

  task automatic reset_start();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  vec_t          tbl[$];
  logic [RW-1:0] recs[$];
  logic [RW-1:0] popped[$];

  function automatic vec_t mk(bit r, s, sp, tv, en, lk, rdy, logic [RW-1:0] d,
                              logic [1:0] es, int ec, bit ev, logic [RW-1:0] ed,
                              bit eg, bit eo, int edr, bit edn);
    vec_t v;
    v.r = r; v.s = s; v.sp = sp; v.tv = tv; v.en = en; v.lk = lk; v.rdy = rdy; v.d = d;
    v.e_st = es; v.e_cnt = ec; v.e_vld = ev; v.e_data = ed;
    v.e_gate = eg; v.e_ovf = eo; v.e_drop = edr; v.e_done = edn;
    return v;
  endfunction

  initial begin
    logic [RW-1:0] hold_d;
    int zc, dc;
    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; lock_i = 1'b0;
    bus.trace_valid_i = 1'b0; bus.trace_capture_enable_i = 1'b0;
    bus.trace_data_i = '0; bus.out_ready_i = 1'b0;

    //            r s sp tv en lk rdy data   st cnt v data  g o dr dn
    tbl.push_back(mk(1,0,0, 0,0,0,0, '0,   0, 0, 0, '0,  0,0,0,0));
    tbl.push_back(mk(0,0,1, 1,1,1,1, RA,   0, 0, 0, '0,  0,0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0,1, '0,   1, 0, 0, '0,  1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,0,1, RA,   1, 1, 1, RA,  1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,0,1, RB,   1, 1, 1, RB,  1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,0,1, RC,   1, 1, 1, RC,  1,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,1, '0,   1, 0, 0, RC,  1,0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0,1, '0,   1, 0, 0, RC,  1,0,0,0));
    tbl.push_back(mk(0,0,1, 0,0,0,1, '0,   2, 0, 0, RC,  0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,1, '0,   3, 0, 0, RC,  0,0,0,1));
    tbl.push_back(mk(0,0,0, 1,1,1,1, RD,   3, 0, 0, RC,  0,0,0,1));
    tbl.push_back(mk(0,1,0, 0,0,0,1, '0,   1, 0, 0, RC,  1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,0,0,1, RD,   1, 0, 0, RC,  1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,0,0, RE,   1, 1, 1, RE,  1,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0, '0,   1, 1, 1, RE,  1,0,0,0));
    tbl.push_back(mk(0,0,1, 0,0,0,0, '0,   2, 1, 1, RE,  0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,1, '0,   2, 0, 0, RE,  0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,1, '0,   3, 0, 0, RE,  0,0,0,1));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].sp, tbl[i].tv, tbl[i].en, tbl[i].lk, tbl[i].rdy, tbl[i].d);
      check($sformatf("vec%0d", i), act_out(),
            pack_out(tbl[i].e_st, tbl[i].e_cnt, tbl[i].e_vld, tbl[i].e_data,
                     tbl[i].e_gate, tbl[i].e_ovf, tbl[i].e_drop, tbl[i].e_done));
    end

    // Overflow: ten pushes into an eight-deep FIFO with the reader stalled.
    reset_start();
    recs.delete();
    for (int i = 0; i < 10; i++) begin
      recs.push_back(rnd96());
      push(recs[i], 1'b0);
    end
    check("ovf_count", 128'(cnt), 128'(8));
    check("ovf_flag", 128'(ovf), 128'(1));
    check("ovf_drops", 128'(drop), 128'(2));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_order%0d", i), {bus.out_valid_o, bus.out_data_o}, {1'b1, recs[i]});
      idle_cyc(1'b1);
    end
    check("ovf_empty", 128'(cnt), 128'(0));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle_cyc(1'b1);
    check("done_holds_ovf", {done, ovf, drop}, {1'b1, 1'b1, 16'd2});
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("start_clears", {st, ovf, drop}, {2'd1, 1'b0, 16'd0});

    // Full FIFO: a push together with a pop is accepted without a drop.
    reset_start();
    recs.delete();
    for (int i = 0; i < 9; i++) recs.push_back(rnd96());
    for (int i = 0; i < 8; i++) push(recs[i], 1'b0);
    check("full_count", {cnt, ovf}, {4'd8, 1'b0});
    push(recs[8], 1'b1);
    check("full_pushpop", {cnt, ovf, drop, bus.out_data_o}, {4'd8, 1'b0, 16'd0, recs[1]});

    // Lock with five buffered records, reader alternating ready/stall.
    reset_start();
    recs.delete();
    popped.delete();
    for (int i = 0; i < 5; i++) begin
      recs.push_back(rnd96());
      push(recs[i], 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("lock_drain", {st, gate, cnt}, {2'd2, 1'b0, 4'd5});
    zc = -1; dc = -1;
    for (int k = 0; k < 40 && dc < 0; k++) begin
      bit rdy;
      bit was_vld;
      rdy = (k % 2 == 0);
      was_vld = bus.out_valid_o;
      hold_d = bus.out_data_o;
      if (was_vld && rdy) popped.push_back(hold_d);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rdy, '0);
      if (was_vld && !rdy)
        check("stall_stable", {bus.out_valid_o, bus.out_data_o}, {1'b1, hold_d});
      if (cnt == '0 && zc < 0) zc = k;
      if (done && dc < 0) dc = k;
    end
    check("drain_timeout", 128'(dc >= 0), 128'(1));
    check("done_latency", 128'(dc), 128'(zc + 1));
    check("drain_n", 128'(popped.size()), 128'(5));
    for (int i = 0; i < 5 && i < popped.size(); i++)
      check($sformatf("drain_order%0d", i), popped[i], recs[i]);

    // Reset in the middle of a drain discards buffered records.
    reset_start();
    for (int i = 0; i < 4; i++) push(rnd96(), 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle_cyc(1'b0);
    check("pre_rst", {st, cnt}, {2'd2, 4'd4});
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("mid_rst", {st, cnt, bus.out_valid_o, done}, {2'd0, 4'd0, 1'b0, 1'b0});

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6,
            $urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 1, rnd96());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
